ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Sequencer that turns the 8x4 dual-address RAM into a synchronous FIFO.
- Takes push/pop requests from a producer and a consumer, keeps the read and write pointers and the occupancy count, and drives the RAM command bus (enable, state code, addresses, write data).
- After every reset it zero-fills the RAM so that stale contents are never read.
- Sits between the RAM macro and the client logic.

Parameters:
- DATA_W, 4: data width; must match the RAM word.
- ADDR_W, 3: RAM address width; DEPTH = 2**ADDR_W = 8.
- AF_THRESH, 6: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request.
- push_data  in  DATA_W  word to write.
- pop  in  1  read request.
- flush  in  1  discard all contents; no RAM clear.
- ready  out  1  high when the INIT sweep is complete.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- pop_data  out  DATA_W  popped word; valid only while pop_valid is high.
- pop_valid  out  1  high for one cycle, the cycle after a pop is accepted.
- ram_enable  out  1  RAM enable.
- ram_state  out  2  RAM command: 0 idle, 1 read, 2 write, 3 read+write.
- ram_data_in  out  DATA_W  RAM write data.
- ram_addr_in  out  ADDR_W  RAM write address.
- ram_addr_out  out  ADDR_W  RAM read address.
- ram_data_out  in  DATA_W  RAM read data; registered, valid the cycle after a read command.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - FSM goes to INIT; wr_ptr, rd_ptr, init_ptr and count go to 0.
  - ready, pop_valid and full go to 0; empty and almost_empty go to 1; almost_full goes to 0.
  - While reset is high, ram_enable, ram_state, ram_addr_* and ram_data_in are forced to 0.
  - pop_data is 0 whenever pop_valid is 0.
- FSM states: INIT and RUN.
- INIT:
  - ram_enable=1, ram_state=2, ram_addr_in=init_ptr, ram_data_in=0.
  - init_ptr increments each cycle; on init_ptr==DEPTH-1, go to RUN.
  - INIT lasts exactly DEPTH cycles; ready goes high on the first RUN cycle.
  - push, pop and flush are ignored during INIT; count stays 0.
- RUN:
  - push_acc = push & !full.
  - pop_acc = pop & !empty.
  - A push while full is rejected even if pop is also high.
  - A pop while empty is rejected even if push is also high; there is no fall-through.
- RAM command in RUN (combinational from registered state and inputs):
  - ram_state = {push_acc, pop_acc}.
  - ram_enable = 1.
  - ram_addr_in = wr_ptr; ram_addr_out = rd_ptr; ram_data_in = push_data.
- Pointer and count update at the edge:
  - push_acc: wr_ptr+1.
  - pop_acc: rd_ptr+1.
  - Both pointers wrap modulo DEPTH (7 -> 0).
  - count: +1 for push only, -1 for pop only, unchanged for both or neither.
- Read latency: one cycle.
  - pop_valid is registered pop_acc.
  - pop_data = ram_data_out while pop_valid is high.
  - Back-to-back pops give one word per cycle.
- Flags: combinational from count, so they reflect the post-edge count.
- flush (RUN only):
  - Pointers and count go to 0 at the edge.
  - push and pop in the same cycle are rejected and no RAM command is issued (ram_state=0).
  - A pop_valid already in flight for the next cycle still completes.
- Simultaneous push and pop at 0 < count < DEPTH: ram_state=3; addresses always differ, so there is no RAM read/write hazard.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds two output ports, err_overflow and err_underflow (1 bit each).
  - err_overflow is sticky; it sets on push & full in RUN.
  - err_underflow is sticky; it sets on pop & empty in RUN.
  - Both clear only on reset or flush; the reset value is 0.
- Not defined: the ports do not exist, and rejected requests are silently dropped.

Test Plan:
- Reset, then release -> ram_state=2 with ram_addr_in 0..7 and ram_data_in=0 over 8 cycles; ready=1 on cycle 9; empty=1, count=0.
- Push 1..8 on consecutive cycles -> ram_addr_in 0..7; count reaches 8; full=1; almost_full=1 from count=6; a 9th push leaves count=8 and wr_ptr=0, and sets err_overflow under FIFO_ERR_FLAGS_EN.
- Pop 8 times from full -> pop_valid high 8 consecutive cycles, each one cycle after its pop, with pop_data 1..8; empty=1 afterwards; a 9th pop gives no pop_valid.
- Fill 4 entries, then push and pop together for 10 cycles -> ram_state=3 each cycle; count stays 4; pointers wrap past 7; the popped data sequence equals the pushed sequence in order.
- Fill 5 entries, assert flush together with push -> count=0, empty=1, ram_state=0 that cycle; the next push lands at address 0.
- Reset asserted mid-stream with count=3 and a pop pending -> pop_valid=0 the next cycle; INIT sweep repeats; a subsequent pop before any push yields no data.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// Client and RAM command bus of the RAM-backed FIFO controller.
// FIFO_ERR_FLAGS_EN adds the sticky err_overflow / err_underflow outputs.
interface ram_fifo_ctrl_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
);
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              flush;
    logic              ready;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              ram_enable;
    logic [1:0]        ram_state;
    logic [DATA_W-1:0] ram_data_in;
    logic [ADDR_W-1:0] ram_addr_in;
    logic [ADDR_W-1:0] ram_addr_out;
    logic [DATA_W-1:0] ram_data_out;
`ifdef FIFO_ERR_FLAGS_EN
    logic              err_overflow;
    logic              err_underflow;
`endif

    // Client side: issues requests, observes status and returns RAM read data.
    modport master (
        output push, push_data, pop, flush, ram_data_out,
        input  ready, full, empty, almost_full, almost_empty, count,
               pop_data, pop_valid, ram_enable, ram_state, ram_data_in,
               ram_addr_in, ram_addr_out
`ifdef FIFO_ERR_FLAGS_EN
        , input err_overflow, err_underflow
`endif
    );

    // Controller side.
    modport slave (
        input  push, push_data, pop, flush, ram_data_out,
        output ready, full, empty, almost_full, almost_empty, count,
               pop_data, pop_valid, ram_enable, ram_state, ram_data_in,
               ram_addr_in, ram_addr_out
`ifdef FIFO_ERR_FLAGS_EN
        , output err_overflow, err_underflow
`endif
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Sequencer turning a dual-address RAM into a synchronous FIFO, with a zero-fill sweep after reset.
// Optional macro FIFO_ERR_FLAGS_EN: sticky overflow/underflow error flags.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 2
) (
    input logic          clk,
    input logic          reset,
    ram_fifo_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_init_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_pop_valid;
    logic              w_run;
    logic              w_full;
    logic              w_empty;
    logic              w_push_acc;
    logic              w_pop_acc;

    assign w_run      = (r_state == ST_RUN) && !reset;
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_acc = w_run && !bus.flush && bus.push && !w_full;
    assign w_pop_acc  = w_run && !bus.flush && bus.pop  && !w_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_next_state;
    end

    // Next state: leave INIT after the last RAM word has been cleared.
    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_INIT && r_init_ptr == ADDR_W'(DEPTH - 1)) w_next_state = ST_RUN;
    end

    // Pointers, occupancy and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_ptr  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_acc;
            if (r_state == ST_INIT) begin
                r_init_ptr <= r_init_ptr + ADDR_W'(1);
            end else if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                if (w_push_acc && !w_pop_acc)      r_count <= r_count + CNT_W'(1);
                else if (w_pop_acc && !w_push_acc) r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // RAM command; everything is held at zero while reset is high.
    always_comb begin
        bus.ram_enable   = 1'b0;
        bus.ram_state    = 2'b00;
        bus.ram_addr_in  = '0;
        bus.ram_addr_out = '0;
        bus.ram_data_in  = '0;
        if (!reset) begin
            case (r_state)
                ST_INIT: begin
                    bus.ram_enable  = 1'b1;
                    bus.ram_state   = 2'b10;
                    bus.ram_addr_in = r_init_ptr;
                end
                ST_RUN: begin
                    bus.ram_enable   = 1'b1;
                    bus.ram_state    = {w_push_acc, w_pop_acc};
                    bus.ram_addr_in  = r_wr_ptr;
                    bus.ram_addr_out = r_rd_ptr;
                    bus.ram_data_in  = bus.push_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready        = (r_state == ST_RUN);
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (r_count <= CNT_W'(AE_THRESH));
    assign bus.count        = r_count;
    assign bus.pop_valid    = r_pop_valid;
    assign bus.pop_data     = r_pop_valid ? bus.ram_data_out : '0;

`ifdef FIFO_ERR_FLAGS_EN
    logic r_err_overflow;
    logic r_err_underflow;

    // Sticky request errors; flush clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (bus.flush) begin
                r_err_overflow  <= 1'b0;
                r_err_underflow <= 1'b0;
            end else begin
                if (bus.push && w_full)  r_err_overflow  <= 1'b1;
                if (bus.pop  && w_empty) r_err_underflow <= 1'b1;
            end
        end
    end

    assign bus.err_overflow  = r_err_overflow;
    assign bus.err_underflow = r_err_underflow;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed test-plan sequences, then random traffic
// against a queue-based FIFO model, with a behavioural RAM attached to the command bus.
module tb_ram_fifo_ctrl;
    logic clk;
    logic reset;

    ram_fifo_ctrl_if #(.DATA_W(4), .ADDR_W(3)) bus ();

    ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x4 RAM with a registered read port.
    logic [3:0] mem [8];
    logic [3:0] ram_q;
    always_ff @(posedge clk) begin
        if (bus.ram_enable) begin
            if (bus.ram_state[1]) mem[bus.ram_addr_in] <= bus.ram_data_in;
            if (bus.ram_state[0]) ram_q <= mem[bus.ram_addr_out];
        end
    end
    assign bus.ram_data_out = ram_q;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int q[$];
    int init_left = 0;
    bit known     = 1'b0;
    bit exp_pv    = 1'b0;
    int exp_pd    = 0;
    int wr_n      = 0;
    int rd_n      = 0;
    bit exp_ov    = 1'b0;
    bit exp_un    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check at negedge, advance model at posedge.
    task automatic step(input bit p, input int d, input bit o, input bit f, input bit r);
        bit pa;
        bit oa;
        int sz;
        pa = 1'b0;
        oa = 1'b0;
        bus.push      = p;
        bus.push_data = 4'(d);
        bus.pop       = o;
        bus.flush     = f;
        reset         = r;
        @(negedge clk);
        sz = q.size();
        if (known) begin
            check("pop_valid", 32'(bus.pop_valid), 32'(exp_pv));
            check("pop_data", 32'(bus.pop_data), exp_pv ? 32'(exp_pd) : 32'd0);
            check("count", 32'(bus.count), 32'(sz));
            check("full", 32'(bus.full), 32'(sz == 8));
            check("empty", 32'(bus.empty), 32'(sz == 0));
            check("almost_full", 32'(bus.almost_full), 32'(sz >= 6));
            check("almost_empty", 32'(bus.almost_empty), 32'(sz <= 2));
            check("ready", 32'(bus.ready), 32'(init_left == 0));
`ifdef FIFO_ERR_FLAGS_EN
            check("err_overflow", 32'(bus.err_overflow), 32'(exp_ov));
            check("err_underflow", 32'(bus.err_underflow), 32'(exp_un));
`endif
        end
        if (r) begin
            check("rst_ram_enable", 32'(bus.ram_enable), 32'd0);
            check("rst_ram_state", 32'(bus.ram_state), 32'd0);
            check("rst_ram_addr_in", 32'(bus.ram_addr_in), 32'd0);
            check("rst_ram_addr_out", 32'(bus.ram_addr_out), 32'd0);
            check("rst_ram_data_in", 32'(bus.ram_data_in), 32'd0);
        end else if (known && init_left > 0) begin
            check("init_ram_enable", 32'(bus.ram_enable), 32'd1);
            check("init_ram_state", 32'(bus.ram_state), 32'd2);
            check("init_ram_addr_in", 32'(bus.ram_addr_in), 32'(8 - init_left));
            check("init_ram_data_in", 32'(bus.ram_data_in), 32'd0);
        end else if (known) begin
            pa = p && !f && sz < 8;
            oa = o && !f && sz > 0;
            check("ram_enable", 32'(bus.ram_enable), 32'd1);
            check("ram_state", 32'(bus.ram_state), 32'({pa, oa}));
            if (pa) begin
                check("ram_addr_in", 32'(bus.ram_addr_in), 32'(wr_n % 8));
                check("ram_data_in", 32'(bus.ram_data_in), 32'(d % 16));
            end
            if (oa) check("ram_addr_out", 32'(bus.ram_addr_out), 32'(rd_n % 8));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            init_left = 8;
            exp_pv    = 1'b0;
            wr_n      = 0;
            rd_n      = 0;
            exp_ov    = 1'b0;
            exp_un    = 1'b0;
            known     = 1'b1;
        end else if (init_left > 0) begin
            init_left--;
            exp_pv = 1'b0;
        end else begin
            exp_pv = oa;
            if (f) begin
                q.delete();
                wr_n   = 0;
                rd_n   = 0;
                exp_ov = 1'b0;
                exp_un = 1'b0;
            end else begin
                if (p && sz == 8) exp_ov = 1'b1;
                if (o && sz == 0) exp_un = 1'b1;
                if (oa) begin
                    exp_pd = q.pop_front();
                    rd_n++;
                end
                if (pa) begin
                    q.push_back(d % 16);
                    wr_n++;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0; bus.flush = 1'b0;
        reset = 1'b1;
        // Reset and INIT sweep, then first RUN cycle.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(8);
        idle(1);
        // Fill to full, then one rejected push.
        for (int i = 1; i <= 8; i++) step(1, i, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        // Drain back-to-back, then one rejected pop.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(2);
        // Fill 4, then simultaneous push/pop across the pointer wrap.
        for (int i = 0; i < 4; i++) step(1, $urandom_range(15), 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, $urandom_range(15), 1, 0, 0);
        // Top up to 5, flush together with push, next push lands at 0.
        step(1, 5, 0, 0, 0);
        step(1, 7, 1, 1, 0);
        step(1, 3, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(1);
        // Three entries, reset with a pop pending, sweep again, pop before any push.
        for (int i = 0; i < 3; i++) step(1, i + 10, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        idle(8);
        step(0, 0, 1, 0, 0);
        idle(1);
        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(1)), int'($urandom_range(15)), 1'($urandom_range(1)),
                 $urandom_range(29) == 0, $urandom_range(149) == 0);
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
